multitap_delay_buffer: RTL and testbench

- Circular-buffer delay line with NUM_TAPS independently programmable read taps sharing one block RAM read port.
- Each accepted input sample is written once, then the taps are read sequentially through the single read port.
- Per-tap outputs, per-tap valid flags and a signed sum of valid taps are presented together on one output strobe.
- Sits in the effects chain ahead of multi-echo/chorus mixing; successor to the single-tap delay buffer.

---
 rtl/multitap_delay_buffer_if.sv | 30 +++
 rtl/multitap_delay_buffer.sv | 155 +++++++++++++++
 tb/tb_multitap_delay_buffer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/multitap_delay_buffer_if.sv
// Sample-in / frame-out bundle for the multitap delay buffer.
// slave is the buffer side, master is the producer/consumer side.
interface multitap_delay_buffer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TAPS   = 4
);
    localparam int MIX_WIDTH = DATA_WIDTH + $clog2(NUM_TAPS);

    logic                           sample_valid;
    logic signed [DATA_WIDTH-1:0]   in_sample;
    logic [NUM_TAPS*ADDR_WIDTH-1:0] delay_samples;
    logic [NUM_TAPS-1:0]            tap_enable;
    logic                           busy;
    logic                           overrun;
    logic [NUM_TAPS*DATA_WIDTH-1:0] out_taps;
    logic [NUM_TAPS-1:0]            out_tap_valid;
    logic signed [MIX_WIDTH-1:0]    out_mix;
    logic                           out_valid;

    modport master (
        output sample_valid, in_sample, delay_samples, tap_enable,
        input  busy, overrun, out_taps, out_tap_valid, out_mix, out_valid
    );

    modport slave (
        input  sample_valid, in_sample, delay_samples, tap_enable,
        output busy, overrun, out_taps, out_tap_valid, out_mix, out_valid
    );
endinterface

// File: rtl/multitap_delay_buffer.sv
// Circular delay line with NUM_TAPS taps read in turn through one RAM port.
// Taps are staged and published together with a signed mix on out_valid.
module multitap_delay_buffer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TAPS   = 4
) (
    input logic                  clk,
    input logic                  reset_n,
    multitap_delay_buffer_if.slave bus
);
    localparam int MW    = DATA_WIDTH + $clog2(NUM_TAPS);
    localparam int CW    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(NUM_TAPS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t state, state_nx;

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];
    logic signed [DATA_WIDTH-1:0] rd_data;

    logic [ADDR_WIDTH-1:0]          wr_ptr, fill_count;
    logic [ADDR_WIDTH-1:0]          base, fill_q;
    logic [NUM_TAPS*ADDR_WIDTH-1:0] dly_q;
    logic [NUM_TAPS-1:0]            en_q;
    logic [CW-1:0]                  rd_idx, cap_idx;
    logic                           cap_en, cap_ok;

    logic [NUM_TAPS*DATA_WIDTH-1:0] stage, stage_nx;
    logic [NUM_TAPS-1:0]            stage_ok, ok_nx;
    logic signed [MW-1:0]           acc, acc_nx;

    logic [NUM_TAPS*DATA_WIDTH-1:0] taps_q;
    logic [NUM_TAPS-1:0]            tvld_q;
    logic signed [MW-1:0]           mix_q;
    logic                           ovalid_q, overrun_q;

    logic                           accept, issue_ok;
    logic [ADDR_WIDTH-1:0]          rd_dly, rd_addr;
    logic signed [DATA_WIDTH-1:0]   cap_val;

    assign accept   = (state == IDLE) && bus.sample_valid;
    assign rd_dly   = dly_q[int'(rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_addr  = base - rd_dly;
    assign issue_ok = en_q[rd_idx] && (rd_dly <= fill_q);
    assign cap_val  = cap_ok ? rd_data : '0;

    assign bus.busy          = (state != IDLE);
    assign bus.overrun       = overrun_q;
    assign bus.out_taps      = taps_q;
    assign bus.out_tap_valid = tvld_q;
    assign bus.out_mix       = mix_q;
    assign bus.out_valid     = ovalid_q;

    // Sample RAM: one write on accept, one registered read per cycle.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= bus.in_sample;
        rd_data <= mem[rd_addr];
    end

    // Frame sequencing: one READ cycle per tap, then a DRAIN cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.sample_valid) state_nx = READ;
            READ:    if (rd_idx == LAST) state_nx = DRAIN;
            DRAIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Write pointer, fill level, per-frame snapshot and read index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            fill_count <= '0;
            base       <= '0;
            fill_q     <= '0;
            dly_q      <= '0;
            en_q       <= '0;
            rd_idx     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                base   <= wr_ptr;
                fill_q <= fill_count;
                dly_q  <= bus.delay_samples;
                en_q   <= bus.tap_enable;
                rd_idx <= '0;
                if (fill_count != '1) fill_count <= fill_count + 1'b1;
            end else if (state == READ && rd_idx != LAST) begin
                rd_idx <= rd_idx + 1'b1;
            end
            if (bus.sample_valid && state != IDLE) overrun_q <= 1'b1;
        end
    end

    // Tag each read with its tap slot and validity for the capture stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_en  <= 1'b0;
            cap_idx <= '0;
            cap_ok  <= 1'b0;
        end else begin
            cap_en  <= (state == READ);
            cap_idx <= rd_idx;
            cap_ok  <= issue_ok;
        end
    end

    // Next staging contents with the tap returning this cycle merged in.
    always_comb begin
        stage_nx = stage;
        ok_nx    = stage_ok;
        acc_nx   = acc;
        if (cap_en) begin
            stage_nx[int'(cap_idx)*DATA_WIDTH +: DATA_WIDTH] = cap_val;
            ok_nx[cap_idx] = cap_ok;
            acc_nx = acc + MW'(cap_val);
        end
        if (accept) acc_nx = '0;
    end

    // Stage taps during the frame; publish them all on the DRAIN edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage    <= '0;
            stage_ok <= '0;
            acc      <= '0;
            taps_q   <= '0;
            tvld_q   <= '0;
            mix_q    <= '0;
            ovalid_q <= 1'b0;
        end else begin
            stage    <= stage_nx;
            stage_ok <= ok_nx;
            acc      <= acc_nx;
            ovalid_q <= (state == DRAIN);
            if (state == DRAIN) begin
                taps_q <= stage_nx;
                tvld_q <= ok_nx;
                mix_q  <= acc_nx;
            end
        end
    end
endmodule

// File: tb/tb_multitap_delay_buffer.sv
// Directed bench: 4-tap/16-bit-address instance for frames, overrun and
// reset; 1-tap/4-bit-address instance for pointer wrap-around.
module tb_multitap_delay_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multitap_delay_buffer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_TAPS(4)) a_if ();
    multitap_delay_buffer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_TAPS(1)) b_if ();

    multitap_delay_buffer #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_TAPS(4)) dut_a (
        .clk(clk), .reset_n(rst_n), .bus(a_if)
    );
    multitap_delay_buffer #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_TAPS(1)) dut_b (
        .clk(clk), .reset_n(rst_n), .bus(b_if)
    );

    typedef struct {
        int          idx;
        int          t [4];
        logic [3:0]  vld;
        int          mix;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic chk_frame(input string name, input int t [4], input logic [3:0] vld, input int mix);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s tap%0d", name, k), 64'($signed(a_if.out_taps[k*32 +: 32])), 64'(t[k]));
        chk({name, " valid"}, 64'(a_if.out_tap_valid), 64'(vld));
        chk({name, " mix"}, 64'(a_if.out_mix), 64'(mix));
    endtask

    task automatic wait_a(output int lat);
        lat = 1;
        while (!a_if.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic send_a(input int v, output int lat);
        @(negedge clk);
        a_if.in_sample = v;
        a_if.sample_valid = 1'b1;
        @(posedge clk); #1;
        a_if.sample_valid = 1'b0;
        wait_a(lat);
    endtask

    task automatic send_b(input int v, output int lat);
        @(negedge clk);
        b_if.in_sample = v;
        b_if.sample_valid = 1'b1;
        @(posedge clk); #1;
        b_if.sample_valid = 1'b0;
        lat = 1;
        while (!b_if.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, j, seen;
        int t [4];

        vt[0] = '{idx: 1,   t: '{1, 0, 0, 0},       vld: 4'b0001, mix: 1};
        vt[1] = '{idx: 2,   t: '{2, 1, 0, 0},       vld: 4'b0011, mix: 3};
        vt[2] = '{idx: 6,   t: '{6, 5, 1, 0},       vld: 4'b0111, mix: 12};
        vt[3] = '{idx: 10,  t: '{10, 9, 5, 0},      vld: 4'b0111, mix: 24};
        vt[4] = '{idx: 100, t: '{100, 99, 95, 0},   vld: 4'b0111, mix: 294};
        vt[5] = '{idx: 101, t: '{101, 100, 96, 1},  vld: 4'b1111, mix: 298};

        a_if.sample_valid = 1'b0;
        a_if.in_sample = '0;
        a_if.delay_samples = {16'd100, 16'd5, 16'd1, 16'd0};
        a_if.tap_enable = 4'b1111;
        b_if.sample_valid = 1'b0;
        b_if.in_sample = '0;
        b_if.delay_samples = 4'd15;
        b_if.tap_enable = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 64'(a_if.busy), 64'd0);
        chk("rst overrun", 64'(a_if.overrun), 64'd0);
        chk("rst out_valid", 64'(a_if.out_valid), 64'd0);
        chk("rst out_taps", 64'(a_if.out_taps != '0), 64'd0);
        chk("rst tap_valid", 64'(a_if.out_tap_valid), 64'd0);
        chk("rst mix", 64'(a_if.out_mix), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        j = 0;
        for (int s = 1; s <= 101; s++) begin
            send_a(s, lat);
            if (j < 6 && vt[j].idx == s) begin
                chk($sformatf("ramp%0d latency", s), 64'(lat), 64'd6);
                chk_frame($sformatf("ramp%0d", s), vt[j].t, vt[j].vld, vt[j].mix);
                j++;
            end
            @(posedge clk); #1;
            if (s == 1) chk("out_valid one cycle", 64'(a_if.out_valid), 64'd0);
            repeat (3) @(posedge clk);
        end
        chk("no overrun yet", 64'(a_if.overrun), 64'd0);

        a_if.tap_enable = 4'b0101;
        a_if.delay_samples = {16'd100, 16'd2, 16'd1, 16'd0};
        for (int s = 1; s <= 6; s++) begin
            send_a((s % 2 == 1) ? 7 : -3, lat);
            if (s == 5) begin
                t = '{7, 0, 7, 0};
                chk_frame("mask pos", t, 4'b0101, 14);
            end
            if (s == 6) begin
                t = '{-3, 0, -3, 0};
                chk_frame("mask neg", t, 4'b0101, -6);
            end
            repeat (4) @(posedge clk);
        end

        a_if.tap_enable = 4'b1111;
        a_if.delay_samples = {16'd3, 16'd2, 16'd1, 16'd0};
        @(negedge clk);
        a_if.in_sample = 500;
        a_if.sample_valid = 1'b1;
        @(posedge clk); #1;
        a_if.sample_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_if.in_sample = 600;
        a_if.sample_valid = 1'b1;
        chk("busy in frame", 64'(a_if.busy), 64'd1);
        @(posedge clk); #1;
        a_if.sample_valid = 1'b0;
        chk("overrun set", 64'(a_if.overrun), 64'd1);
        wait_a(lat);
        chk("overrun frame seen", 64'(a_if.out_valid), 64'd1);
        chk("busy at out_valid", 64'(a_if.busy), 64'd0);
        t = '{500, -3, 7, -3};
        chk_frame("ovr frame", t, 4'b1111, 501);
        a_if.in_sample = 700;
        a_if.sample_valid = 1'b1;
        @(posedge clk); #1;
        a_if.sample_valid = 1'b0;
        wait_a(lat);
        chk("b2b latency", 64'(lat), 64'd6);
        t = '{700, 500, -3, 7};
        chk_frame("b2b frame", t, 4'b1111, 1204);
        chk("overrun sticky", 64'(a_if.overrun), 64'd1);
        repeat (4) @(posedge clk);

        @(negedge clk);
        a_if.in_sample = 77;
        a_if.sample_valid = 1'b1;
        @(posedge clk); #1;
        a_if.sample_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst busy", 64'(a_if.busy), 64'd0);
        chk("arst overrun", 64'(a_if.overrun), 64'd0);
        chk("arst out_valid", 64'(a_if.out_valid), 64'd0);
        chk("arst out_taps", 64'(a_if.out_taps != '0), 64'd0);
        chk("arst tap_valid", 64'(a_if.out_tap_valid), 64'd0);
        chk("arst mix", 64'(a_if.out_mix), 64'd0);
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (a_if.out_valid) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (a_if.out_valid) seen++;
        end
        chk("aborted frame silent", 64'(seen), 64'd0);
        send_a(42, lat);
        chk("post-reset latency", 64'(lat), 64'd6);
        t = '{42, 0, 0, 0};
        chk_frame("post-reset", t, 4'b0001, 42);
        repeat (4) @(posedge clk);

        for (int s = 1; s <= 40; s++) begin
            send_b(s, lat);
            if (s == 1) chk("wrap latency", 64'(lat), 64'd3);
            chk($sformatf("wrap%0d tap", s), 64'($signed(b_if.out_taps)),
                64'((s >= 16) ? s - 15 : 0));
            chk($sformatf("wrap%0d valid", s), 64'(b_if.out_tap_valid),
                64'((s >= 16) ? 1 : 0));
            chk($sformatf("wrap%0d mix", s), 64'(b_if.out_mix),
                64'((s >= 16) ? s - 15 : 0));
            repeat (2) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
